hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RV32 core. It sits beside the Fetch/Decode/Execute/Memory/Writeback stage blocks and drives their stall and flush controls and the Execute operand forwarding muxes. It also freezes the whole pipe while data memory is not ready, with a timeout watchdog.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_fwd_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// sequencing FSM states and the register-compare helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } hazard_state_e;

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != REG_ZERO) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Execute-stage operand forwarding comparator; one instance per ALU operand.
// Memory-stage results take priority over Writeback since they are younger.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_w_i,
  input  logic [4:0] rd_w_i,
  output logic [1:0] fwd_sel_o
);

  always_comb begin
    fwd_sel_o = FWD_RF;
    if (reg_hit(reg_write_m_i, rd_m_i, rs_e_i)) begin
      fwd_sel_o = FWD_MEM;
    end else if (reg_hit(reg_write_w_i, rd_w_i, rs_e_i)) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage RV32 pipe, with a data-memory
// freeze watchdog. Define HAZARD_PERF_EN to build the stall/flush perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned TO_W        = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [4:0]  RS1_E,
  input  logic [4:0]  RS2_E,
  input  logic [4:0]  RD_E,
  input  logic        ResultSrcE,
  input  logic        PCSrcE,
  input  logic        RegWriteM,
  input  logic [4:0]  RD_M,
  input  logic        RegWriteW,
  input  logic [4:0]  RD_W,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        StallW,
  output logic        FlushD,
  output logic        FlushE,
  output logic        mem_err,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
);

  localparam logic [TO_W-1:0] TIMEOUT      = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [1:0]      fwd_a, fwd_b;
  logic            load_use, freeze;
  hazard_state_e   state_q;
  logic [TO_W-1:0] cnt_q;

  hazard_fwd_sel u_fwd_a (
    .rs_e_i        (RS1_E),
    .reg_write_m_i (RegWriteM),
    .rd_m_i        (RD_M),
    .reg_write_w_i (RegWriteW),
    .rd_w_i        (RD_W),
    .fwd_sel_o     (fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_e_i        (RS2_E),
    .reg_write_m_i (RegWriteM),
    .rd_m_i        (RD_M),
    .reg_write_w_i (RegWriteW),
    .rd_w_i        (RD_W),
    .fwd_sel_o     (fwd_b)
  );

  assign load_use = ResultSrcE && (RD_E != REG_ZERO) && ((RD_E == RS1_D) || (RD_E == RS2_D));
  assign freeze   = dmem_req && !dmem_ready;

  // All controls are held inactive while reset is asserted.
  assign ForwardAE = rst ? fwd_a : FWD_RF;
  assign ForwardBE = rst ? fwd_b : FWD_RF;

  // A taken branch redirects the PC, so a load-use stall on the wrong path is dropped.
  assign StallF = rst && (freeze || (load_use && !PCSrcE));
  assign StallD = StallF;
  assign StallE = rst && freeze;
  assign StallM = StallE;
  assign StallW = StallE;

  // A frozen branch stays in Execute; its flush fires in the first unfrozen cycle.
  assign FlushD = rst && PCSrcE && !freeze;
  assign FlushE = rst && (PCSrcE || load_use) && !freeze;

  // cnt_q counts consecutive not-ready cycles including the one that entered S_WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      mem_err <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (freeze) begin
            state_q <= S_WAIT;
            cnt_q   <= TO_W'(1);
          end
        end
        S_WAIT: begin
          if (freeze) begin
            if (cnt_q != TIMEOUT) begin
              cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q >= TIMEOUT_LAST) begin
              mem_err <= 1'b1;
            end
          end else begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= S_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (StallF || StallE) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (FlushD || FlushE) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_stall = 32'h0;
  assign perf_flush = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic        ResultSrcE, PCSrcE, RegWriteM, RegWriteW, dmem_req, dmem_ready;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, mem_err;
  logic [31:0] perf_stall, perf_flush;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  int unsigned wait_cnt = 0;
  int unsigned ps_m     = 0;
  int unsigned pf_m     = 0;
  bit          err_m    = 1'b0;
  bit          exp_frz, exp_stall_any, exp_flush_any;

  hazard_ctrl #(
    .MEM_TIMEOUT (TIMEOUT),
    .TO_W        (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RS1_D      (RS1_D),
    .RS2_D      (RS2_D),
    .RS1_E      (RS1_E),
    .RS2_E      (RS2_E),
    .RD_E       (RD_E),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .RegWriteM  (RegWriteM),
    .RD_M       (RD_M),
    .RegWriteW  (RegWriteW),
    .RD_W       (RD_W),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .StallW     (StallW),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .mem_err    (mem_err),
    .perf_stall (perf_stall),
    .perf_flush (perf_flush)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (RegWriteM && RD_M != 5'd0 && RD_M == rs) return 2'b10;
    if (RegWriteW && RD_W != 5'd0 && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clr_inputs();
    {RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W} = '0;
    {ResultSrcE, PCSrcE, RegWriteM, RegWriteW, dmem_req, dmem_ready} = '0;
  endtask

  // Settle combinational outputs and compare everything against the model.
  task automatic eval(input string tag);
    bit lw, sf, se, fd, fe;
    logic [1:0] ea, eb;
    logic [31:0] eps, epf;
    #1;
    if (!rst) begin
      wait_cnt = 0;
      err_m    = 1'b0;
      ps_m     = 0;
      pf_m     = 0;
    end
    exp_frz = dmem_req && !dmem_ready;
    lw = ResultSrcE && RD_E != 5'd0 && (RD_E == RS1_D || RD_E == RS2_D);
    sf = rst && (exp_frz || (lw && !PCSrcE));
    se = rst && exp_frz;
    fd = rst && PCSrcE && !exp_frz;
    fe = rst && (PCSrcE || lw) && !exp_frz;
    exp_stall_any = sf || se;
    exp_flush_any = fd || fe;
    ea = rst ? fwd_ref(RS1_E) : 2'b00;
    eb = rst ? fwd_ref(RS2_E) : 2'b00;
`ifdef HAZARD_PERF_EN
    eps = ps_m;
    epf = pf_m;
`else
    eps = 32'd0;
    epf = 32'd0;
`endif
    check_eq({tag, ".fwdA"}, 32'(ForwardAE), 32'(ea));
    check_eq({tag, ".fwdB"}, 32'(ForwardBE), 32'(eb));
    check_eq({tag, ".stall"}, 32'({StallF, StallD, StallE, StallM, StallW}),
             32'({sf, sf, se, se, se}));
    check_eq({tag, ".flush"}, 32'({FlushD, FlushE}), 32'({fd, fe}));
    check_eq({tag, ".mem_err"}, 32'(mem_err), 32'(err_m));
    check_eq({tag, ".perf_stall"}, perf_stall, eps);
    check_eq({tag, ".perf_flush"}, perf_flush, epf);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      if (exp_frz) begin
        if (wait_cnt < 1000) wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
      if (wait_cnt >= TIMEOUT) err_m = 1'b1;
      if (exp_stall_any) ps_m++;
      if (exp_flush_any) pf_m++;
    end
    @(negedge clk);
  endtask

  task automatic cycle(input string tag);
    eval(tag);
    advance();
  endtask

  initial begin
    clr_inputs();
    @(negedge clk);
    @(negedge clk);
    // Inputs that would otherwise stall/flush/forward must be masked in reset.
    ResultSrcE = 1'b1; RD_E = 5'd3; RS1_D = 5'd3; PCSrcE = 1'b1;
    RegWriteM = 1'b1; RD_M = 5'd2; RS1_E = 5'd2;
    cycle("reset");
    check_eq("reset.flushD", 32'(FlushD), 32'd0);
    rst = 1'b1;
    clr_inputs();

    // Forwarding priority, M over W
    RegWriteM = 1'b1; RD_M = 5'd5; RS1_E = 5'd5;
    RegWriteW = 1'b1; RD_W = 5'd5; RS2_E = 5'd5;
    eval("fwd_prio");
    check_eq("fwd_prio.A", 32'(ForwardAE), 32'd2);
    check_eq("fwd_prio.B", 32'(ForwardBE), 32'd2);
    advance();
    RD_W = 5'd6; RS2_E = 5'd6;
    eval("fwd_wb");
    check_eq("fwd_wb.A", 32'(ForwardAE), 32'd2);
    check_eq("fwd_wb.B", 32'(ForwardBE), 32'd1);
    advance();

    // x0 never forwarded
    clr_inputs();
    RegWriteM = 1'b1; RD_M = 5'd0; RS1_E = 5'd0;
    eval("fwd_x0");
    check_eq("fwd_x0.A", 32'(ForwardAE), 32'd0);
    advance();

    // Load-use stall, then bubble clears it
    clr_inputs();
    ResultSrcE = 1'b1; RD_E = 5'd7; RS2_D = 5'd7;
    eval("lw");
    check_eq("lw.stallFD", 32'({StallF, StallD}), 32'b11);
    check_eq("lw.flushDE", 32'({FlushD, FlushE}), 32'b01);
    advance();
    ResultSrcE = 1'b0; RD_E = 5'd0;
    eval("lw_after");
    check_eq("lw_after.all", 32'({StallF, StallD, FlushD, FlushE}), 32'd0);
    advance();

    // Load-use overridden by taken branch
    ResultSrcE = 1'b1; RD_E = 5'd7; RS2_D = 5'd7; PCSrcE = 1'b1;
    eval("lw_br");
    check_eq("lw_br.stallFD", 32'({StallF, StallD}), 32'b00);
    check_eq("lw_br.flushDE", 32'({FlushD, FlushE}), 32'b11);
    advance();

    // Freeze with a pending branch: flush deferred until ready
    clr_inputs();
    PCSrcE = 1'b1; dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eval("frz_br");
      check_eq("frz_br.stall", 32'({StallF, StallD, StallE, StallM, StallW}), 32'h1f);
      check_eq("frz_br.flush", 32'({FlushD, FlushE}), 32'd0);
      advance();
    end
    dmem_ready = 1'b1;
    eval("frz_rel");
    check_eq("frz_rel.flush", 32'({FlushD, FlushE}), 32'b11);
    check_eq("frz_rel.mem_err", 32'(mem_err), 32'd0);
    advance();

    // Watchdog: 6 not-ready cycles from a fresh reset
    clr_inputs();
    rst = 1'b0;
    cycle("rst2");
    rst = 1'b1;
    dmem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      eval("to");
      check_eq("to.mem_err", 32'(mem_err), (i >= int'(TIMEOUT)) ? 32'd1 : 32'd0);
      advance();
    end
    dmem_ready = 1'b1;
    eval("to_rel");
    check_eq("to_rel.mem_err", 32'(mem_err), 32'd1);
`ifdef HAZARD_PERF_EN
    check_eq("to_rel.perf_stall", perf_stall, 32'd6);
`endif
    advance();
    clr_inputs();
    cycle("to_sticky");
    rst = 1'b0;
    eval("to_rst");
    check_eq("to_rst.mem_err", 32'(mem_err), 32'd0);
    advance();
    rst = 1'b1;

    // Random traffic, with occasional asynchronous reset pulses
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) != 0);
      RS1_D      = 5'($urandom_range(0, 3));
      RS2_D      = 5'($urandom_range(0, 3));
      RS1_E      = 5'($urandom_range(0, 3));
      RS2_E      = 5'($urandom_range(0, 3));
      RD_E       = 5'($urandom_range(0, 3));
      RD_M       = 5'($urandom_range(0, 3));
      RD_W       = 5'($urandom_range(0, 3));
      ResultSrcE = ($urandom_range(0, 3) == 0);
      PCSrcE     = ($urandom_range(0, 3) == 0);
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      dmem_req   = ($urandom_range(0, 3) != 0);
      dmem_ready = ($urandom_range(0, 2) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
